// File: rtl/mux_pkg.sv
// Shared defaults and pointer arithmetic for the round-robin mux stage.
package mux_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_NUM_CH = 4;

    function automatic int next_ptr(input int g, input int n);
        return (g + 1) % n;
    endfunction

endpackage

// File: rtl/rr_mux_stage_arbiter.sv
// Round-robin / forced-select arbiter; owns the rotating priority pointer.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              force_en,
    input  logic [CH_W-1:0]   force_sel,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    logic [CH_W-1:0] ptr;
    logic            found;

    // Scan ptr..NUM_CH-1 first, then 0..ptr-1; the first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        if (force_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (CH_W'(i) == force_sel && req[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = CH_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && req[i] && i >= int'(ptr)) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = CH_W'(i);
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && req[i] && i < int'(ptr)) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = CH_W'(i);
                end
            end
        end
    end

    // Forced grants leave the pointer alone so round-robin resumes where it was.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && !force_en && (|grant)) begin
            ptr <= CH_W'(next_ptr(int'(grant_idx), NUM_CH));
        end
    end

endmodule

// File: rtl/rr_mux_stage.sv
// N-channel registered mux with per-channel valid/ready and a single output register.
module rr_mux_stage
    import mux_pkg::*;
#(
    parameter  int WIDTH  = DEFAULT_WIDTH,
    parameter  int NUM_CH = DEFAULT_NUM_CH,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    force_en,
    input  logic [CH_W-1:0]         force_sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic              load;
    logic              advance;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic [WIDTH-1:0]  sel_data;
    logic [WIDTH-1:0]  data_p1;
    logic [CH_W-1:0]   ch_p1;
    logic              vld_p1;

    assign load    = !vld_p1 || out_ready;
    assign advance = rst_n && load;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .force_en  (force_en),
        .force_sel (force_sel),
        .advance   (advance),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign in_ready = advance ? grant : '0;

    // One-hot AND-OR select keeps in_data off any combinational output path.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_p1 <= '0;
            ch_p1   <= '0;
            vld_p1  <= 1'b0;
        end else if (load) begin
            if (|grant) begin
                data_p1 <= sel_data;
                ch_p1   <= grant_idx;
                vld_p1  <= 1'b1;
            end else begin
                vld_p1  <= 1'b0;
            end
        end
    end

    assign out_data  = data_p1;
    assign out_ch    = ch_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_rr_mux_stage.sv
// Self-checking bench for rr_mux_stage: directed scenarios plus random traffic vs a queue-free reference.
module tb_rr_mux_stage;

    localparam int WIDTH  = 16;
    localparam int NUM_CH = 4;
    localparam int CH_W   = $clog2(NUM_CH);

    logic                    clk;
    logic                    rst_n;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic                    force_en;
    logic [CH_W-1:0]         force_sel;
    logic [WIDTH-1:0]        out_data;
    logic [CH_W-1:0]         out_ch;
    logic                    out_valid;
    logic                    out_ready;

    int vectors;
    int errors;

    // Reference state: rotating start channel plus the held output word.
    int             m_ptr;
    int             m_ch;
    logic [WIDTH-1:0] m_data;
    logic           m_vld;

    rr_mux_stage #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .force_en  (force_en),
        .force_sel (force_sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Channel the rules pick right now, or -1 for none.
    function automatic int model_grant();
        if (force_en) begin
            if (int'(force_sel) < NUM_CH && in_valid[force_sel]) return int'(force_sel);
            return -1;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            int c;
            c = (m_ptr + k) % NUM_CH;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic model_load();
        return !m_vld || out_ready;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_ready();
        int g;
        g = model_grant();
        if (!rst_n || !model_load() || g < 0) return '0;
        return NUM_CH'(1) << g;
    endfunction

    // Advance one clock, updating the reference from the inputs seen at the edge.
    task automatic tick();
        int               g;
        int               n_ptr;
        int               n_ch;
        logic [WIDTH-1:0] n_data;
        logic             n_vld;
        g      = model_grant();
        n_ptr  = m_ptr;
        n_ch   = m_ch;
        n_data = m_data;
        n_vld  = m_vld;
        if (!rst_n) begin
            n_ptr = 0; n_ch = 0; n_data = '0; n_vld = 1'b0;
        end else if (model_load()) begin
            if (g >= 0) begin
                n_data = in_data[g*WIDTH +: WIDTH];
                n_ch   = g;
                n_vld  = 1'b1;
                if (!force_en) n_ptr = (g + 1) % NUM_CH;
            end else begin
                n_vld = 1'b0;
            end
        end
        @(posedge clk);
        m_ptr = n_ptr; m_ch = n_ch; m_data = n_data; m_vld = n_vld;
        #1;
    endtask

    task automatic set_data(input int base);
        for (int i = 0; i < NUM_CH; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(base + i);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; force_en = 1'b0; force_sel = '0; in_valid = '0; out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = '1; out_ready = 1'b1; force_en = 1'b0; set_data(16'h5500);
        tick(); tick();
        vectors++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got=%b want=0000", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        vectors++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got=%h want=0000", out_data); end
        vectors++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch got=%0d want=0", out_ch); end
        rst_n = 1'b1; #1;
        vectors++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got=%b want=0001", in_ready); end
        tick();
        vectors++; if (out_ch !== 2'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL reset_first_out ch=%0d vld=%b want ch=0 vld=1", out_ch, out_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        set_data(16'h1000); in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++; if (out_valid !== 1'b1 || out_ch !== CH_W'(i % NUM_CH) || out_data !== WIDTH'(16'h1000 + i % NUM_CH)) begin
                errors++; $display("FAIL rr_seq[%0d] got vld=%b ch=%0d data=%h want vld=1 ch=%0d data=%h",
                                   i, out_valid, out_ch, out_data, i % NUM_CH, 16'h1000 + i % NUM_CH);
            end
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        set_data(16'h2000); out_ready = 1'b1;
        in_valid = 4'b0100; tick();
        in_valid = 4'b0101; #1;
        vectors++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ready got=%b want=0001", in_ready); end
        tick();
        vectors++; if (out_ch !== 2'd0 || out_data !== 16'h2000) begin errors++; $display("FAIL wrap_out ch=%0d data=%h want ch=0 data=2000", out_ch, out_data); end
        vectors++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL skip_ready got=%b want=0100", in_ready); end
        tick();
        vectors++; if (out_ch !== 2'd2 || out_data !== 16'h2002) begin errors++; $display("FAIL skip_out ch=%0d data=%h want ch=2 data=2002", out_ch, out_data); end
    endtask

    task automatic test_forced();
        do_reset();
        set_data(16'h4000); out_ready = 1'b1;
        in_valid = 4'b0001; tick();
        force_en = 1'b1; force_sel = 2'd2; in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL force_ready[%0d] got=%b want=0100", i, in_ready); end
            tick();
            vectors++; if (out_ch !== 2'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL force_out[%0d] ch=%0d vld=%b want ch=2 vld=1", i, out_ch, out_valid); end
        end
        force_en = 1'b0; #1;
        vectors++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL force_ptr_kept got=%b want=0010", in_ready); end
        force_en = 1'b1; in_valid = 4'b1011; #1;
        vectors++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL force_idle_ready got=%b want=0000", in_ready); end
        tick();
        vectors++; if (out_valid !== 1'b0 || out_ch !== 2'd2) begin errors++; $display("FAIL force_idle_out vld=%b ch=%0d want vld=0 ch=2", out_valid, out_ch); end
        force_en = 1'b0;
    endtask

    task automatic test_back_pressure();
        do_reset();
        in_data = '0; in_data[1*WIDTH +: WIDTH] = 16'hBEEF;
        in_valid = 4'b0010; out_ready = 1'b1; tick();
        vectors++; if (out_data !== 16'hBEEF || out_valid !== 1'b1) begin errors++; $display("FAIL bp_load data=%h vld=%b want BEEF 1", out_data, out_valid); end
        out_ready = 1'b0; in_valid = 4'b1111; set_data(16'h3000);
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got=%b want=0000", i, in_ready); end
            tick();
            vectors++; if (out_data !== 16'hBEEF || out_valid !== 1'b1 || out_ch !== 2'd1) begin
                errors++; $display("FAIL bp_hold[%0d] data=%h vld=%b ch=%0d want BEEF 1 1", i, out_data, out_valid, out_ch);
            end
        end
        out_ready = 1'b1; #1;
        vectors++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got=%b want=0100", in_ready); end
        tick();
        vectors++; if (out_data !== 16'h3002 || out_ch !== 2'd2 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_no_bubble data=%h ch=%0d vld=%b want 3002 2 1", out_data, out_ch, out_valid);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_data(16'h6000); in_valid = 4'b1111; out_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b0; #1;
        vectors++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ready got=%b want=0000", in_ready); end
        tick();
        vectors++; if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_ch !== 2'd0) begin
            errors++; $display("FAIL midrst_out vld=%b data=%h ch=%0d want 0 0000 0", out_valid, out_data, out_ch);
        end
        rst_n = 1'b1; #1;
        vectors++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL midrst_ptr got=%b want=0001", in_ready); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NUM_CH; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            in_valid  = NUM_CH'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            force_en  = ($urandom_range(0, 4) == 0);
            force_sel = CH_W'($urandom);
            rst_n     = ($urandom_range(0, 49) != 0);
            #1;
            vectors++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready[%0d] got=%b want=%b", n, in_ready, exp_ready()); end
            tick();
            vectors++; if (out_valid !== m_vld || out_data !== m_data || int'(out_ch) != m_ch) begin
                errors++; $display("FAIL rand_out[%0d] vld=%b data=%h ch=%0d want vld=%b data=%h ch=%0d",
                                   n, out_valid, out_data, out_ch, m_vld, m_data, m_ch);
            end
        end
        rst_n = 1'b1; force_en = 1'b0;
    endtask

    initial begin
        vectors = 0; errors = 0;
        m_ptr = 0; m_ch = 0; m_data = '0; m_vld = 1'b0;
        rst_n = 1'b0; in_data = '0; in_valid = '0; force_en = 1'b0; force_sel = '0; out_ready = 1'b1;
        test_reset();
        test_round_robin();
        test_wrap_skip();
        test_forced();
        test_back_pressure();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_stage.md
Name: rr_mux_stage

Overview:
- Parametrised successor to the team's 2:1 datapath mux: N-channel, WIDTH-bit registered multiplexer with a valid/ready handshake per channel.
- Round-robin arbitration between requesting channels by default; an external select override reproduces fixed-select mux behaviour.
- Sits between producers (ALU, register-file read ports, I/O) and a single shared consumer. Output is registered.

Parameters:
- WIDTH, 16, data width of every channel and of the output.
- NUM_CH, 4, number of input channels; must be ≥2.
- CH_W, $clog2(NUM_CH), width of channel index (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_data  input  NUM_CH*WIDTH  packed channel data; channel i at [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel request.
- in_ready  output  NUM_CH  per-channel accept; a transfer occurs when in_valid[i] and in_ready[i] are both high.
- force_en  input  1  1 = fixed-select mode; 0 = round-robin.
- force_sel  input  CH_W  channel selected when force_en=1.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  CH_W  index of the channel that supplied out_data.
- out_valid  output  1  out_data/out_ch are valid.
- out_ready  input  1  consumer accept.

Behaviour:
- Reset:
  - Applied on the clk edge while rst_n=0.
  - Sets out_data=0, out_ch=0, out_valid=0 and the round-robin pointer ptr=0.
  - in_ready is all-zero while rst_n=0.
  - Reset mid-transfer discards any held output word.
- Load enable: load = !out_valid || out_ready. A single output register; no skid buffer.
- Round-robin grant (force_en=0, load=1):
  - Grant the first channel with in_valid set, scanning ptr, ptr+1, …, NUM_CH-1, then 0, …, ptr-1.
  - Exactly one in_ready bit is high, at the granted channel; all others are 0.
  - If no channel is valid, no grant is made.
- Forced grant (force_en=1, load=1):
  - Grant channel force_sel if in_valid[force_sel]=1.
  - If force_sel ≥ NUM_CH, make no grant.
  - ptr is unchanged in forced mode.
- Transfer on grant to channel g:
  - Next edge: out_data=in_data[g], out_ch=g, out_valid=1.
  - In round-robin mode, ptr=(g+1) mod NUM_CH, wrapping NUM_CH-1 to 0.
- No grant with load=1: next edge sets out_valid=0; out_data and out_ch hold their values.
- load=0 (out_valid=1, out_ready=0):
  - All in_ready are 0; out_data, out_ch, out_valid and ptr hold.
  - Output is stable under back-pressure.
- Latency and throughput: one cycle from accept to out_valid. Full throughput is one word per cycle while out_ready=1.
- Simultaneous out_ready=1 and a new grant: the old word retires and the new word loads on the same edge, with no bubble.
- in_ready is combinational from in_valid, force_en, force_sel, ptr, out_valid and out_ready. There is no combinational path from in_data to any output.
- Mode switch: force_en may change on any cycle and takes effect in that cycle's grant. ptr resumes from its last round-robin value.

Decomposition:
- Package mux_pkg holds:
  - DEFAULT_WIDTH=16 and DEFAULT_NUM_CH=4.
  - A helper function next_ptr(g, n) returning (g+1) mod n.
- One sub-module, rr_arbiter(NUM_CH):
  - Inputs: req, force_en, force_sel, advance.
  - Outputs: one-hot grant and grant index.
  - Owns the ptr register.
  - rr_mux_stage owns the data/valid output register and the load logic.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all in_valid=1 → in_ready=0000, out_valid=0, out_data=0x0000, out_ch=0. After release, the first grant is channel 0.
- Round-robin fairness: in_valid=1111, out_ready=1, data ch i=0x1000+i → out_ch sequence 0,1,2,3,0,… and out_data 0x1000,0x1001,0x1002,0x1003,0x1000, one word per cycle.
- Pointer wrap/skip: ptr=3, in_valid=0101 → grant ch0. Next cycle in_valid=0101 → grant ch2, skipping the idle ch1.
- Forced mode: force_en=1, force_sel=2, in_valid=1111 → only in_ready[2]=1 and out_ch=2 repeatedly; ptr is unchanged. force_sel=2 with in_valid[2]=0 → out_valid drops to 0.
- Back-pressure: out_valid=1 with out_data=0xBEEF and out_ready=0 for 3 cycles → in_ready=0000 and out_data holds 0xBEEF. Then out_ready=1 → the next word loads with no bubble.
- Mid-stream reset: rst_n=0 for one cycle while out_valid=1 → next edge out_valid=0, out_data=0, ptr=0.
